// File: rtl/axis_clip_reg.sv
// rtl/axis_clip_reg.sv - multi-channel saturating clip register with AXI-Stream handshake
// One register stage narrows each signed channel and tracks clip events.
module axis_clip_reg #(
  parameter int WIDTH_IN  = 24,
  parameter int WIDTH_OUT = 16,
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic [NUM_CH*WIDTH_IN-1:0]    i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          i_tready,
  output logic [NUM_CH*WIDTH_OUT-1:0]   o_tdata,
  output logic                          o_tlast,
  output logic                          o_tvalid,
  input  logic                          o_tready,
  output logic [NUM_CH-1:0]             sat_sticky,
  output logic [CNT_W-1:0]              sat_count
);

  localparam int HDR_W = WIDTH_IN - WIDTH_OUT + 1;

  logic [NUM_CH*WIDTH_OUT-1:0] clip_data;
  logic [NUM_CH-1:0]           clip_mask;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [WIDTH_IN-1:0] smp;
    assign smp = i_tdata[ch*WIDTH_IN +: WIDTH_IN];

    if (WIDTH_OUT == WIDTH_IN) begin : g_pass
      assign clip_data[ch*WIDTH_OUT +: WIDTH_OUT] = smp;
      assign clip_mask[ch]                        = 1'b0;
    end else begin : g_clip
      localparam logic [WIDTH_OUT-1:0] MAX_V = {1'b0, {(WIDTH_OUT-1){1'b1}}};
      localparam logic [WIDTH_OUT-1:0] MIN_V = {1'b1, {(WIDTH_OUT-1){1'b0}}};
      logic [HDR_W-1:0] hdr;
      logic             clip;

      // A value fits when every bit above the output sign bit repeats that sign bit.
      assign hdr  = smp[WIDTH_IN-1 -: HDR_W];
      assign clip = (|hdr) & ~(&hdr);
      assign clip_mask[ch] = clip;
      assign clip_data[ch*WIDTH_OUT +: WIDTH_OUT] =
        clip ? (smp[WIDTH_IN-1] ? MIN_V : MAX_V) : smp[WIDTH_OUT-1:0];
    end
  end

  logic [NUM_CH*WIDTH_OUT-1:0] tdata_d,  tdata_q;
  logic                        tlast_d,  tlast_q;
  logic                        tvalid_d, tvalid_q;
  logic [NUM_CH-1:0]           sticky_d, sticky_q;
  logic [CNT_W-1:0]            count_d,  count_q;
  logic                        accept;

  assign i_tready = ~tvalid_q | o_tready;
  assign accept   = i_tvalid & i_tready;

  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (accept) begin
      tdata_d  = clip_data;
      tlast_d  = i_tlast;
      tvalid_d = 1'b1;
    end else if (o_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // Clear is applied first so a clipping beat in the same cycle still registers.
  always_comb begin
    sticky_d = clear ? '0 : sticky_q;
    count_d  = clear ? '0 : count_q;
    if (accept) begin
      sticky_d = sticky_d | clip_mask;
      if ((|clip_mask) && (count_d != {CNT_W{1'b1}})) begin
        count_d = count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      sticky_q <= '0;
      count_q  <= '0;
    end else begin
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign o_tdata    = tdata_q;
  assign o_tlast    = tlast_q;
  assign o_tvalid   = tvalid_q;
  assign sat_sticky = sticky_q;
  assign sat_count  = count_q;

endmodule
